// File: rtl/cdb_broadcaster.sv
// Common data bus producer: buffers one completed result per functional unit
// and broadcasts one per cycle on a registered CDB, chosen by round-robin.
`timescale 1ns/1ps
module cdb_broadcaster #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_SRC  = 3,
  parameter int TAG_FREE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [TAG_W-1:0] TAG_FREE_L = TAG_W'(TAG_FREE);

  logic [NUM_SRC-1:0] buf_v_q, buf_v_d;
  logic [TAG_W-1:0]   buf_tag_q  [NUM_SRC];
  logic [TAG_W-1:0]   buf_tag_d  [NUM_SRC];
  logic [DATA_W-1:0]  buf_data_q [NUM_SRC];
  logic [DATA_W-1:0]  buf_data_d [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic [PTR_W-1:0]   win_idx;
  logic               any_grant;
  int unsigned        idx;

  // Round-robin search: first valid buffer at or after rr_ptr wins.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!any_grant && buf_v_q[idx]) begin
        any_grant  = 1'b1;
        win_idx    = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // A buffer draining this cycle can take a new result on the same edge.
  assign src_ready = rst ? '1 : ({NUM_SRC{!flush}} & (~buf_v_q | grant));

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      accept[i]     = src_valid[i] & src_ready[i] &
                      (src_tag[i*TAG_W +: TAG_W] != TAG_FREE_L);
      buf_tag_d[i]  = buf_tag_q[i];
      buf_data_d[i] = buf_data_q[i];
      buf_v_d[i]    = buf_v_q[i];
      if (flush) begin
        buf_v_d[i] = 1'b0;
      end else if (accept[i]) begin
        buf_v_d[i]    = 1'b1;
        buf_tag_d[i]  = src_tag[i*TAG_W +: TAG_W];
        buf_data_d[i] = src_data[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        buf_v_d[i] = 1'b0;
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (any_grant && !flush)
      rr_ptr_d = (int'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + PTR_W'(1);

    cdb_valid_d = any_grant & !flush;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (any_grant) begin
      cdb_tag_d  = buf_tag_q[win_idx];
      cdb_data_d = buf_data_q[win_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v_q     <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= TAG_FREE_L;
      cdb_data_q  <= '0;
    end else begin
      buf_v_q     <= buf_v_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  // Payload storage is qualified by buf_v, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      buf_tag_q[i]  <= buf_tag_d[i];
      buf_data_q[i] <= buf_data_d[i];
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: cycle vectors, hand sequences and a broadcast scoreboard.
`timescale 1ns/1ps
module tb_cdb_broadcaster;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int NS = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic [NS-1:0]  src_valid = '0;
  logic [NS-1:0]  src_ready;
  logic [NS*TW-1:0] src_tag = '0;
  logic [NS*DW-1:0] src_data = '0;
  logic           cdb_valid;
  logic [TW-1:0]  cdb_tag;
  logic [DW-1:0]  cdb_data;

  int errors = 0;
  int checks = 0;
  logic [TW+DW-1:0] sb_q [$];

  cdb_broadcaster #(.DATA_W(DW), .TAG_W(TW), .NUM_SRC(NS), .TAG_FREE(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] v;
    logic [TW-1:0] t0, t1, t2;
    logic [DW-1:0] d0, d1, d2;
    logic          fl;
    logic [NS-1:0] rdy;
    logic          cv;
    logic          chk_t;
    logic [TW-1:0] ct;
    logic [DW-1:0] cd;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic [NS-1:0] v, logic [TW-1:0] t0, logic [TW-1:0] t1,
                              logic [TW-1:0] t2, logic [DW-1:0] d0, logic [DW-1:0] d1,
                              logic [DW-1:0] d2, logic fl, logic [NS-1:0] rdy, logic cv,
                              logic chk_t, logic [TW-1:0] ct, logic [DW-1:0] cd);
    vec_t r;
    r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.fl = fl; r.rdy = rdy; r.cv = cv; r.chk_t = chk_t; r.ct = ct; r.cd = cd;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every valid broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && cdb_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got tag %h data %h, want no broadcast", cdb_tag, cdb_data);
      end else begin
        logic [TW+DW-1:0] e;
        e = sb_q.pop_front();
        if ({cdb_tag, cdb_data} !== e) begin
          errors++;
          $display("FAIL sb_broadcast: got tag %h data %h, want tag %h data %h",
                   cdb_tag, cdb_data, e[TW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    int cyc, acc2_cyc, seen2_cyc, s0_tag;
    logic r0;

    // idle / single source
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 0, 0));
    vecs.push_back(mk(3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 3'b111, 0, 1, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 1, 5, 32'hDEADBEEF));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 5, 0));
    // back-to-back on src1
    vecs.push_back(mk(3'b010, 0, 5, 0, 0, 1, 0, 0, 3'b111, 0, 1, 5, 0));
    vecs.push_back(mk(3'b010, 0, 6, 0, 0, 2, 0, 0, 3'b111, 1, 1, 5, 1));
    vecs.push_back(mk(3'b010, 0, 7, 0, 0, 3, 0, 0, 3'b111, 1, 1, 6, 2));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 1, 7, 3));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 7, 0));
    // src2 once so rr_ptr wraps to 0
    vecs.push_back(mk(3'b100, 0, 0, 9, 0, 0, 9, 0, 3'b111, 0, 1, 7, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 1, 9, 9));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 9, 0));
    // three-way contention from rr_ptr = 0
    vecs.push_back(mk(3'b111, 1, 2, 3, 11, 22, 33, 0, 3'b111, 0, 1, 9, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 1, 1, 11));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b011, 1, 1, 2, 22));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 1, 3, 33));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 3, 0));
    // TAG_FREE is consumed, never broadcast
    vecs.push_back(mk(3'b001, 0, 0, 0, 32'h1234, 0, 0, 0, 3'b111, 0, 1, 3, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 3, 0));
    // flush with buffers 0 and 2 full
    vecs.push_back(mk(3'b101, 4, 0, 8, 44, 0, 88, 0, 3'b111, 0, 1, 3, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0));
    vecs.push_back(mk(3'b010, 0, 12, 0, 0, 32'hC0FFEE, 0, 0, 3'b111, 0, 0, 0, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 1, 12, 32'hC0FFEE));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 12, 0));

    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_cdb_valid", 32'(cdb_valid), 0);
    check("rst_cdb_tag", 32'(cdb_tag), 0);
    check("rst_src_ready", 32'(src_ready), 32'b111);
    #2 rst = 1'b0;
    step();

    foreach (vecs[n]) begin
      src_valid = vecs[n].v;
      src_tag   = {vecs[n].t2, vecs[n].t1, vecs[n].t0};
      src_data  = {vecs[n].d2, vecs[n].d1, vecs[n].d0};
      flush     = vecs[n].fl;
      #1;
      check($sformatf("vec%0d_ready", n), 32'(src_ready), 32'(vecs[n].rdy));
      if (vecs[n].cv) sb_q.push_back({vecs[n].ct, vecs[n].cd});
      step();
      check($sformatf("vec%0d_cdb_valid", n), 32'(cdb_valid), 32'(vecs[n].cv));
      if (vecs[n].chk_t)
        check($sformatf("vec%0d_cdb_tag", n), 32'(cdb_tag), 32'(vecs[n].ct));
    end
    src_valid = '0; flush = 1'b0;

    // Fairness: src0 streams tags 1..4 (held until ready), src2 offers tag 10 once.
    sb_q.push_back({4'd1, 32'h100});
    sb_q.push_back({4'd10, 32'hAAAA});
    sb_q.push_back({4'd2, 32'h200});
    sb_q.push_back({4'd3, 32'h300});
    sb_q.push_back({4'd4, 32'h400});
    cyc = 0; acc2_cyc = 0; seen2_cyc = 0; s0_tag = 1;
    while (s0_tag <= 4 && cyc < 20) begin
      src_valid = {cyc == 1, 1'b0, 1'b1};
      src_tag   = {4'd10, 4'd0, 4'(s0_tag)};
      src_data  = {32'hAAAA, 32'h0, 32'(s0_tag * 256)};
      #1;
      r0 = src_ready[0];
      if (cyc == 1 && src_ready[2]) acc2_cyc = 2;
      step();
      cyc++;
      if (r0) s0_tag++;
      if (cdb_valid && cdb_tag == 4'd10) seen2_cyc = cyc;
    end
    src_valid = '0;
    for (int i = 0; i < 3; i++) step();
    check("fair_src2_accepted", 32'(acc2_cyc), 2);
    check("fair_src2_latency_ok",
          32'((seen2_cyc > acc2_cyc) && (seen2_cyc - acc2_cyc <= NS)), 1);

    // Asynchronous reset mid-cycle with buffers full.
    src_valid = 3'b111;
    src_tag   = {4'd3, 4'd2, 4'd1};
    src_data  = {32'h3, 32'h2, 32'h1};
    step();
    src_valid = '0;
    step();
    #1 rst = 1'b1;
    #1;
    check("async_rst_cdb_valid", 32'(cdb_valid), 0);
    check("async_rst_cdb_tag", 32'(cdb_tag), 0);
    check("async_rst_src_ready", 32'(src_ready), 32'b111);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst%0d_cdb_valid", i), 32'(cdb_valid), 0);
      check($sformatf("post_rst%0d_src_ready", i), 32'(src_ready), 32'b111);
    end

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer side of the register-file tag protocol. The register file hands out rename tags at read time; this block returns results to the tag owners.
- Collects completed results (tag + data) from NUM_SRC functional units through valid/ready handshakes, holds them in per-source buffers, and picks one per cycle by round-robin.
- The winner is driven onto the registered common data bus (CDB). The register file and reservation stations consume the CDB to clear tags and capture data.

Parameters:
- DATA_W, 32, result data width (matches dataWidth).
- TAG_W, 4, rename tag width (matches tagWidth).
- NUM_SRC, 3, number of functional-unit result ports (2..8).
- TAG_FREE, 0, reserved "no producer" tag value. It is never broadcast.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- flush  in  1  synchronous pipeline flush (mispredict).
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source buffer can accept.
- src_tag  in  NUM_SRC*TAG_W  packed tags; source i at [i*TAG_W +: TAG_W].
- src_data  in  NUM_SRC*DATA_W  packed data; source i at [i*DATA_W +: DATA_W].
- cdb_valid  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag, registered.
- cdb_data  out  DATA_W  broadcast data, registered.

Behaviour:
- Reset:
  - rst is asynchronous, active-high.
  - While rst is high: all buf_v = 0, rr_ptr = 0, cdb_valid = 0, cdb_tag = TAG_FREE, cdb_data = 0.
  - src_ready is combinational. It reads all-ones while rst is high, but no handshake is recorded.
  - Reset mid-operation discards all buffered results.
- Buffers:
  - One entry per source: buf_v[i], buf_tag[i], buf_data[i].
- Ready:
  - src_ready[i] = !flush & (!buf_v[i] | grant[i]).
  - Combinational, with no dependence on src_valid[i].
- Accept:
  - On a clock edge with src_valid[i] & src_ready[i] and src_tag[i] != TAG_FREE: buffer i loads tag/data, buf_v[i] = 1.
  - A handshake carrying TAG_FREE completes (it is consumed) but is not stored.
- Arbitration (combinational, each cycle):
  - Candidates are i with buf_v[i] = 1.
  - Search starts at rr_ptr and ascends modulo NUM_SRC; the first candidate wins (grant one-hot, or zero when no candidate).
  - If any grant at edge: rr_ptr <= winner + 1 mod NUM_SRC. With no grant, rr_ptr holds.
- Broadcast:
  - At each edge: cdb_valid <= |grant & !flush; cdb_tag/cdb_data <= winner's buffer.
  - With no winner, cdb_valid <= 0 and cdb_tag/cdb_data hold their previous values.
- Simultaneous grant and accept:
  - When the granted buffer also accepts a new result on the same edge, it stays valid with the new contents.
  - Otherwise buf_v[i] clears when granted.
- Latency and throughput:
  - A result accepted at edge E0 appears on the CDB from edge E1 (one cycle after acceptance) if uncontested.
  - Sustained throughput is one broadcast per cycle total.
  - A single uncontested source sustains one result per cycle.
- Flush:
  - Synchronous. At the edge: all buf_v <= 0 and cdb_valid <= 0; rr_ptr is unchanged.
  - src_ready is 0 during the flush cycle, so nothing is accepted.
  - A cdb_valid already high during the flush cycle stays visible for that cycle; consumers decide its use.
- Starvation freedom:
  - Any valid buffer is granted within NUM_SRC cycles.
- Ordering:
  - No ordering guarantee across sources.
  - Per source, results broadcast in acceptance order, since depth is 1.

Test Plan:
- Reset / idle:
  - Assert rst async mid-cycle with buffers full -> cdb_valid = 0 and cdb_tag = 0 immediately.
  - After release with no src_valid -> cdb_valid stays 0 and src_ready = 3'b111.
- Single source:
  - Src1 presents tag 5 / data 0xDEADBEEF at edge E0 -> cdb_valid = 1, tag 5, data 0xDEADBEEF from E1 for exactly one cycle.
  - Back-to-back tags 5, 6, 7 on consecutive cycles -> CDB shows 5, 6, 7 on consecutive cycles; src_ready[1] stays 1.
- Contention, round-robin:
  - All three sources valid at the same edge with tags 1, 2, 3 (rr_ptr = 0) -> CDB order 1, 2, 3 on consecutive cycles.
  - src_ready[2] = 0 while buffer 2 waits.
  - rr_ptr ends at 0.
- Fairness:
  - Src0 is valid every cycle with new tags while src2 is valid once -> src2's tag is broadcast within 3 cycles of acceptance.
- TAG_FREE drop:
  - Src0 presents tag 0 with data 0x1234 -> handshake completes; cdb_valid stays 0.
- Flush:
  - Buffers 0 and 2 full, assert flush one cycle -> cdb_valid = 0 the next cycle; no buffered tag ever appears.
  - src_ready = 0 during the flush cycle.
  - A new result after the flush broadcasts normally.
